// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin bus scheduler.
// The scheduler moves packets from driver FIFOs to destination FIFOs.
package bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  localparam int              ID_W     = 8;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

  // Widest packet and ID that dest_of can handle.
  localparam int MAX_PKT = 256;
  localparam int MAX_ID  = 32;

  // Returns the top w bits of an sz-bit packet, zero-extended to MAX_ID bits.
  function automatic logic [MAX_ID-1:0] dest_of(input logic [MAX_PKT-1:0] pkt,
                                                input int sz, input int w);
    logic [MAX_ID-1:0] mask;
    mask = (MAX_ID'(1) << w) - MAX_ID'(1);
    return MAX_ID'(pkt >> (sz - w)) & mask;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker. The search starts at the index after
// i_last and wraps, using a doubled request vector.
module rr_picker #(
  parameter int drvrs = 4
) (
  input  logic [drvrs-1:0]         i_req,
  input  logic [$clog2(drvrs)-1:0] i_last,
  output logic [$clog2(drvrs)-1:0] o_grant,
  output logic                     o_any_req
);

  localparam int IW = $clog2(drvrs);

  logic [2*drvrs-1:0] w_dbl;
  logic [drvrs-1:0]   w_rot;
  logic [IW:0]        w_off;
  logic [IW:0]        w_sum;

  assign w_dbl = {i_req, i_req};

  // w_rot[0] is the request one position after the last grant.
  for (genvar gi = 0; gi < drvrs; gi++) begin : g_rot
    assign w_rot[gi] = w_dbl[{1'b0, i_last} + (IW+1)'(gi + 1)];
  end

  always_comb begin
    w_off = '0;
    for (int i = drvrs - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = (IW+1)'(i);
    end
  end

  assign w_sum     = {1'b0, i_last} + (IW+1)'(1) + w_off;
  assign o_grant   = (w_sum >= (IW+1)'(drvrs)) ? IW'(w_sum - (IW+1)'(drvrs)) : IW'(w_sum);
  assign o_any_req = |i_req;

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler for the shared packet bus. It pops one packet from
// the granted driver FIFO, then pushes it to one destination or broadcasts it.
module bus_rr_scheduler
  import bus_sched_pkg::*;
#(
  parameter int              drvrs    = 4,
  parameter int              pckg_sz  = 16,
  parameter int              id_w     = ID_W,
  parameter logic [id_w-1:0] bcast_id = BCAST_ID
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
  output logic                            err,
  output logic [31:0]                     pkt_cnt,
  output logic [15:0]                     drop_cnt
);

  localparam int IW = $clog2(drvrs);

  state_t             r_state;
  state_t             w_state_next;
  logic [IW-1:0]      r_grant;
  logic [IW-1:0]      r_last;
  logic [pckg_sz-1:0] r_pkt;
  logic [31:0]        r_pkt_cnt;
  logic [15:0]        r_drop_cnt;

  logic [IW-1:0]      w_pick;
  logic               w_any;
  logic [MAX_ID-1:0]  w_dest;
  logic               w_is_bcast;
  logic               w_uni_ok;
  logic               w_deliver;
  logic [drvrs-1:0]   w_push_mask;

  rr_picker #(
    .drvrs(drvrs)
  ) u_picker (
    .i_req    (pndng),
    .i_last   (r_last),
    .o_grant  (w_pick),
    .o_any_req(w_any)
  );

  // Destination decode of the captured packet.
  assign w_dest     = dest_of(MAX_PKT'(r_pkt), pckg_sz, id_w);
  assign w_is_bcast = (w_dest == MAX_ID'(bcast_id));
  assign w_uni_ok   = (w_dest < MAX_ID'(drvrs)) && (w_dest != MAX_ID'(r_grant));
  assign w_deliver  = w_is_bcast || w_uni_ok;

  for (genvar gi = 0; gi < drvrs; gi++) begin : g_lane
    assign w_push_mask[gi] = w_is_bcast ? (IW'(gi) != r_grant)
                                        : (w_uni_ok && (w_dest == MAX_ID'(gi)));
    assign D_push[gi]      = r_pkt;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_next = POP;
      POP:     w_state_next = PUSH;
      PUSH:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    pop  = '0;
    push = '0;
    err  = 1'b0;
    case (r_state)
      POP:  pop[r_grant] = 1'b1;
      PUSH: begin
        push = w_push_mask;
        err  = ~w_deliver;
      end
      default: ;
    endcase
  end

  // A reset during POP discards the in-flight packet before it is counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant    <= '0;
      r_last     <= IW'(drvrs - 1);
      r_pkt      <= '0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (r_state == IDLE && w_any) r_grant <= w_pick;
      if (r_state == POP) begin
        r_pkt  <= D_pop[r_grant];
        r_last <= r_grant;
      end
      if (r_state == PUSH) begin
        if (w_deliver)                   r_pkt_cnt  <= r_pkt_cnt + 32'd1;
        else if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Bench for bus_rr_scheduler. It models the driver FIFOs with queues and
// predicts the delivery order from the round-robin rule into a scoreboard.
module tb_bus_rr_scheduler;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       pndng;
  logic [3:0][15:0] D_pop;
  logic [3:0]       pop;
  logic [3:0]       push;
  logic [3:0][15:0] D_push;
  logic             err;
  logic [31:0]      pkt_cnt;
  logic [15:0]      drop_cnt;

  always #5 clk = ~clk;

  bus_rr_scheduler #(
    .drvrs(4), .pckg_sz(16), .id_w(8), .bcast_id(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .err(err),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  typedef struct {
    int         src;
    logic [3:0] mask;
    logic [15:0] data;
    logic       err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] fq[4][$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          m_last = 3;
  logic [31:0] m_pkt = 0;
  logic [15:0] m_drop = 0;
  int          last_pop_src = -1;
  int          last_pop_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Driver FIFO model: a pop seen during a cycle removes the head at the next edge.
  initial begin
    logic [3:0] p;
    pndng = '0;
    D_pop = '0;
    forever begin
      @(negedge clk);
      p = pop;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (p[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        pndng[i] = (fq[i].size() > 0);
        D_pop[i] = (fq[i].size() > 0) ? fq[i][0] : 16'h0000;
      end
    end
  end

  // Monitor: each push or err is compared with the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pop != 4'b0000) begin
        check("pop_onehot", 64'($onehot(pop)), 64'd1);
        for (int i = 0; i < 4; i++) if (pop[i]) last_pop_src = i;
        last_pop_cyc = cyc;
      end
      if (push != 4'b0000 || err) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_push: got push=%b err=%b expected no output", push, err);
        end else begin
          e = sb.pop_front();
          check("grant_src", 64'(last_pop_src), 64'(e.src));
          check("push_mask", 64'(push), 64'(e.mask));
          check("err_pulse", 64'(err), 64'(e.err));
          check("pop_to_push", 64'(cyc - last_pop_cyc), 64'd1);
          if (!e.err)
            for (int i = 0; i < 4; i++) check("d_push_lane", 64'(D_push[i]), 64'(e.data));
        end
      end
    end
  end

  // Reference: scan from the previous grant, wrapping, over the loaded queues.
  task automatic predict();
    int   used[4];
    int   total;
    int   g;
    logic [15:0] pkt;
    logic [7:0]  dest;
    exp_t e;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      used[i] = 0;
      total += fq[i].size();
    end
    while (total > 0) begin
      g = -1;
      for (int k = 1; k <= 4; k++) begin
        if (g < 0 && fq[(m_last + k) % 4].size() > used[(m_last + k) % 4]) g = (m_last + k) % 4;
      end
      pkt  = fq[g][used[g]];
      used[g]++;
      total--;
      m_last = g;
      dest   = pkt[15:8];
      e.src  = g;
      e.data = pkt;
      e.err  = 1'b0;
      if (dest == 8'hFF) e.mask = 4'hF & ~(4'b0001 << g);
      else if (dest < 8'd4 && int'(dest) != g) e.mask = 4'b0001 << dest;
      else begin
        e.mask = 4'b0000;
        e.err  = 1'b1;
      end
      if (e.err) m_drop = (m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1;
      else       m_pkt  = m_pkt + 32'd1;
      sb.push_back(e);
    end
  endtask

  function automatic bit busy();
    return sb.size() != 0 || fq[0].size() != 0 || fq[1].size() != 0 ||
           fq[2].size() != 0 || fq[3].size() != 0;
  endfunction

  task automatic drain(input string tag);
    int t = 0;
    while (busy() && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d entries pending expected 0", tag, sb.size());
      sb.delete();
      for (int i = 0; i < 4; i++) fq[i].delete();
    end
    repeat (3) @(negedge clk);
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(m_pkt));
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic send_one(input int d, input logic [15:0] pkt, input string tag);
    @(negedge clk);
    fq[d].push_back(pkt);
    predict();
    drain(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    m_last = 3;
    m_pkt  = 0;
    m_drop = 0;
  endtask

  initial begin
    int          t;
    int          n;
    int          r;
    logic [7:0]  dest;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pop", 64'(pop), 64'd0);
    check("rst_push", 64'(push), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_dpush", 64'(D_push), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single unicast with cycle-exact latency.
    @(negedge clk);
    fq[1].push_back(16'h02AB);
    predict();
    @(negedge clk);
    check("uni_idle_pop", 64'(pop), 64'd0);
    @(negedge clk);
    check("uni_pop", 64'(pop), 64'b0010);
    @(negedge clk);
    check("uni_push", 64'(push), 64'b0100);
    check("uni_dpush", 64'(D_push[2]), 64'h02AB);
    drain("unicast");

    send_one(2, 16'hFF55, "bcast");
    send_one(3, 16'h0311, "self_drop");
    send_one(0, 16'h0711, "range_drop");

    // Round robin with all drivers loaded from reset.
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      for (int d = 0; d < 4; d++)
        fq[d].push_back({8'((d + 1) % 4), 8'($urandom)});
    predict();
    drain("round_robin");

    // Reset during the POP cycle aborts the packet.
    @(negedge clk);
    fq[1].push_back(16'h0033);
    t = 0;
    while (pop == 4'b0000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("abort_saw_pop", 64'(pop), 64'b0010);
    reset = 1'b1;
    @(negedge clk);
    check("abort_pop", 64'(pop), 64'd0);
    check("abort_push", 64'(push), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    check("abort_dpush", 64'(D_push), 64'd0);
    check("abort_pkt_cnt", 64'(pkt_cnt), 64'd0);
    reset = 1'b0;
    m_last = 3;
    m_pkt  = 0;
    m_drop = 0;
    for (int i = 0; i < 4; i++) fq[i].delete();
    repeat (2) @(negedge clk);
    send_one(3, 16'h0144, "after_abort");

    // Idle: no pending drivers, nothing should move.
    repeat (100) begin
      @(negedge clk);
      check("idle_quiet", 64'({pop, push, err}), 64'd0);
    end
    check("idle_pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
    check("idle_drop_cnt", 64'(drop_cnt), 64'(m_drop));

    // Randomized rounds with a mix of unicast, broadcast and bad IDs.
    for (int round = 0; round < 10; round++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        n = $urandom_range(0, 4);
        for (int k = 0; k < n; k++) begin
          r = $urandom_range(0, 9);
          if (r < 6)      dest = 8'($urandom_range(0, 3));
          else if (r < 8) dest = 8'hFF;
          else            dest = 8'($urandom_range(4, 254));
          fq[d].push_back({dest, 8'($urandom)});
        end
      end
      predict();
      drain("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_rr_scheduler.md
Name: bus_rr_scheduler

Overview:
- Round-robin scheduler that shares the packet bus among DRVRS driver FIFOs.
- Polls the pndng flags, pops one packet from the granted source, decodes the destination ID in the packet header, and pushes the packet to the destination FIFO or FIFOs.
- Sits between the per-driver FIFOs (pndng/pop/D_pop) and the receive side (push/D_push). It sequences the shared bus in the same way as the bus generator/arbiter.

Parameters:
- drvrs, 4, number of driver ports; 2..16.
- pckg_sz, 16, packet width in bits; at least 9.
- id_w, 8, width of the destination-ID field in packet bits [pckg_sz-1 -: id_w].
- bcast_id, 8'hFF, destination ID meaning "all drivers except the source".

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pndng  in  drvrs  per-driver "FIFO not empty".
- D_pop  in  drvrs x pckg_sz  per-driver FIFO head data, first-word-fall-through.
- pop  out  drvrs  one-hot pop strobe to the granted FIFO.
- push  out  drvrs  push strobe per destination; multi-hot on broadcast.
- D_push  out  drvrs x pckg_sz  data to each destination; all lanes carry the same packet.
- err  out  1  one-cycle pulse when a packet is dropped.
- pkt_cnt  out  32  count of delivered packets; a broadcast counts as 1.
- drop_cnt  out  16  count of dropped packets; saturates at 16'hFFFF.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: pop=0, push=0, D_push=0, err=0, pkt_cnt=0, drop_cnt=0.
  - State = IDLE.
  - last_grant = drvrs-1, so driver 0 has top priority first.
  - Reset asserted mid-packet aborts the packet: no push occurs and it is not counted. A FIFO already popped loses that word, which is acceptable.
- FSM states: IDLE, POP, PUSH. Transitions IDLE->POP->PUSH->IDLE.
- IDLE:
  - If pndng != 0, pick g = first index set in pndng, scanning last_grant+1 upward with wrap. Register g and go to POP.
  - Otherwise stay in IDLE.
- POP (one cycle):
  - pop[g]=1 only.
  - Capture pkt=D_pop[g].
  - last_grant=g.
  - Next state PUSH.
- PUSH (one cycle). dest = pkt upper id_w bits.
  - Broadcast, dest==bcast_id: push[i]=1 for all i != g.
  - Unicast, dest<drvrs and dest!=g: push[dest]=1.
  - In both cases above, D_push[all]=pkt and pkt_cnt+1.
  - Otherwise (dest==g, or dest>=drvrs and dest!=bcast_id): no push, err=1, drop_cnt+1 (saturating).
  - Next state IDLE.
- Timing:
  - pndng seen high at edge T gives pop at T+1 and push at T+2.
  - Peak throughput is 1 packet per 3 cycles.
- pndng changes during POP or PUSH are ignored until the next IDLE.
- If pndng[g] has dropped by the POP cycle, pop is still issued; the FIFO must ignore pop when empty.
- Fairness: with all drivers pending continuously, grants go 0,1,..,drvrs-1,0,...
  - No driver waits more than drvrs grants.
- D_push holds its last value outside PUSH. push is zero outside PUSH.
- pkt_cnt wraps at 2^32.

Decomposition:
- Package bus_sched_pkg:
  - state enum {IDLE, POP, PUSH}.
  - ID_W and BCAST_ID defaults.
  - Function dest_of(pkt) that extracts the ID field.
- Sub-module rr_picker:
  - Combinational.
  - Inputs req[drvrs] and last[$clog2(drvrs)].
  - Outputs grant index and any_req.
  - Implemented with a doubled-vector priority scan.

Test Plan:
- Single unicast: after reset, pndng=4'b0010, D_pop[1]=16'h02AB → pop=4'b0010 at T+1, push=4'b0100 with D_push=16'h02AB at T+2, pkt_cnt=1.
- Round robin: pndng=4'b1111 held for 12 packets, each destination valid → grant order 0,1,2,3,0,1,2,3,0,1,2,3; pop never multi-hot.
- Broadcast: driver 2 sends 16'hFF55 → push=4'b1011, all lanes 16'hFF55, pkt_cnt increments by 1.
- Drops:
  - Self-send: driver 3 sends 16'h0311 → no push, err pulse, drop_cnt=1.
  - Out-of-range: driver 0 sends 16'h0711 → drop_cnt=2.
- Reset mid-packet: assert reset in the POP cycle → in the next cycle all outputs are 0 and state is IDLE, no push occurs. After release with pndng=4'b1000, driver 3 is granted.
- Idle: pndng=0 for 100 cycles → pop, push and err stay 0 and counters are unchanged.
